// File: rtl/key_strobe_pkg.sv
// Shared types and helpers for the multi-channel key strobe stretcher.
package key_strobe_pkg;

  localparam int MAX_CHANNELS = 16;

  // LOCKED is the all-zero encoding so reset lands there without a special case.
  typedef enum logic [2:0] {
    ST_LOCKED    = 3'd0,
    ST_IDLE      = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RPT_DLY   = 3'd3,
    ST_RPT_PULSE = 3'd4,
    ST_RPT_GAP   = 3'd5
  } chan_state_e;

  function automatic int code_width(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  function automatic logic [3:0] lowest_set(input logic [MAX_CHANNELS-1:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_strobe_chan.sv
// One key channel: stretches a held detect level into a fixed strobe, with
// optional typematic repeat pulses, and exposes the next strobe value.
module key_strobe_chan
  import key_strobe_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int HOLD_CYCLES  = 10000000,
  parameter int REPEAT_DELAY = 5000000,
  parameter int PULSE_CYCLES = 1000000,
  parameter int REPEAT_GAP   = 2000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic detect,
  input  logic repeat_en,
  output logic strobe,
  output logic strobe_next
);

  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) >= CNT_LIM ||
      REPEAT_DELAY < 1 || longint'(REPEAT_DELAY) >= CNT_LIM ||
      PULSE_CYCLES < 1 || longint'(PULSE_CYCLES) >= CNT_LIM ||
      REPEAT_GAP < 1 || longint'(REPEAT_GAP) >= CNT_LIM) begin : g_bad_cycles
    $error("key_strobe_chan: cycle parameters must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LD   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(REPEAT_GAP - 1);

  chan_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_strobe, w_strobe_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero  = (r_cnt == '0);
  assign strobe      = r_strobe;
  assign strobe_next = w_strobe_nxt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; reset forces LOCKED so a key held through
  // reset must be released before it can strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_LOCKED;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_strobe_nxt = r_strobe;
    if (!detect) begin
      w_state_nxt  = ST_IDLE;
      w_strobe_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt  = ST_HOLD;
          w_cnt_nxt    = HOLD_LD;
          w_strobe_nxt = 1'b1;
        end
        ST_HOLD: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_strobe_nxt = 1'b0;
            if (repeat_en) begin
              w_state_nxt = ST_RPT_DLY;
              w_cnt_nxt   = DLY_LD;
            end else begin
              w_state_nxt = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: w_strobe_nxt = 1'b0;
        ST_RPT_DLY, ST_RPT_PULSE, ST_RPT_GAP: begin
          if (!repeat_en) begin
            w_state_nxt  = ST_LOCKED;
            w_strobe_nxt = 1'b0;
          end else if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else if (r_state == ST_RPT_PULSE) begin
            w_state_nxt  = ST_RPT_GAP;
            w_cnt_nxt    = GAP_LD;
            w_strobe_nxt = 1'b0;
          end else begin
            w_state_nxt  = ST_RPT_PULSE;
            w_cnt_nxt    = PULSE_LD;
            w_strobe_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt  = ST_LOCKED;
          w_strobe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_strobe_multi.sv
// Multi-channel key strobe stretcher with a registered priority event encoder
// reporting which channel's strobe rose on each cycle.
module key_strobe_multi
  import key_strobe_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 24,
  parameter int HOLD_CYCLES  = 10000000,
  parameter int REPEAT_DELAY = 5000000,
  parameter int PULSE_CYCLES = 1000000,
  parameter int REPEAT_GAP   = 2000000,
  localparam int CODE_W      = code_width(CHANNELS)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] detect,
  input  logic                repeat_en,
  output logic [CHANNELS-1:0] strobe,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_multi
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("key_strobe_multi: CHANNELS must be in 1..16");
  end

  logic [CHANNELS-1:0]     w_strobe, w_strobe_nxt, w_rise;
  logic [MAX_CHANNELS-1:0] w_rise_pad;
  logic                    r_key_valid, r_key_multi;
  logic [CODE_W-1:0]       r_key_code;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    key_strobe_chan #(
      .CNT_W       (CNT_W),
      .HOLD_CYCLES (HOLD_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .PULSE_CYCLES(PULSE_CYCLES),
      .REPEAT_GAP  (REPEAT_GAP)
    ) u_chan (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .detect     (detect[g]),
      .repeat_en  (repeat_en),
      .strobe     (w_strobe[g]),
      .strobe_next(w_strobe_nxt[g])
    );
  end

  // Rise is taken from the next strobe so the registered event lines up with the strobe edge.
  assign w_rise     = w_strobe_nxt & ~w_strobe;
  assign w_rise_pad = MAX_CHANNELS'(w_rise);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_multi <= 1'b0;
    end else begin
      r_key_valid <= |w_rise;
      r_key_multi <= ($countones(w_rise) > 1);
      if (|w_rise) r_key_code <= CODE_W'(lowest_set(w_rise_pad));
    end
  end

  assign strobe    = w_strobe;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_multi = r_key_multi;

endmodule

// File: tb/tb_key_strobe_multi.sv
// Directed bench for key_strobe_multi: a press-age model checked every cycle,
// plus literal expectations at the notable cycles of each scenario.
module tb_key_strobe_multi;

  localparam int CH   = 4;
  localparam int HOLD = 4;
  localparam int RD   = 3;
  localparam int PC   = 1;
  localparam int RG   = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [CH-1:0] detect = '0;
  logic          repeat_en = 1'b0;
  logic [CH-1:0] strobe;
  logic          key_valid;
  logic [1:0]    key_code;
  logic          key_multi;

  key_strobe_multi #(
    .CHANNELS    (CH),
    .CNT_W       (24),
    .HOLD_CYCLES (HOLD),
    .REPEAT_DELAY(RD),
    .PULSE_CYCLES(PC),
    .REPEAT_GAP  (RG)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .detect   (detect),
    .repeat_en(repeat_en),
    .strobe   (strobe),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_multi(key_multi)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Model: a channel is armed once it has seen detect low since reset; its
  // strobe is a function of how many edges the current press has lasted.
  int            age[CH] = '{default: 0};
  bit            armed[CH] = '{default: 1'b0};
  bit            dead[CH] = '{default: 1'b0};
  logic [CH-1:0] m_strobe = '0;
  logic [CH-1:0] m_next, m_rise;
  logic          m_valid = 1'b0;
  logic          m_multi = 1'b0;
  logic [1:0]    m_code = '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int c = 0; c < CH; c++) begin
        age[c] = 0; armed[c] = 1'b0; dead[c] = 1'b0;
      end
      m_strobe = '0; m_valid = 1'b0; m_multi = 1'b0; m_code = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (!detect[c]) begin
          armed[c] = 1'b1; age[c] = 0; dead[c] = 1'b0; m_next[c] = 1'b0;
        end else if (!armed[c]) begin
          m_next[c] = 1'b0;
        end else begin
          age[c]++;
          if (age[c] >= HOLD + 1 && !repeat_en) dead[c] = 1'b1;
          if (dead[c])                m_next[c] = 1'b0;
          else if (age[c] <= HOLD)      m_next[c] = 1'b1;
          else if (age[c] <= HOLD + RD) m_next[c] = 1'b0;
          else m_next[c] = (((age[c] - HOLD - RD - 1) % (PC + RG)) < PC);
        end
      end
      m_rise  = m_next & ~m_strobe;
      m_valid = |m_rise;
      m_multi = ($countones(m_rise) > 1);
      for (int i = CH - 1; i >= 0; i--) if (m_rise[i]) m_code = 2'(i);
      m_strobe = m_next;
    end
  end

  always @(negedge CLK) begin
    check("model_strobe", 32'(strobe), 32'(m_strobe));
    check("model_key_valid", 32'(key_valid), 32'(m_valid));
    check("model_key_code", 32'(key_code), 32'(m_code));
    check("model_key_multi", 32'(key_multi), 32'(m_multi));
  end

  initial begin
    logic [20:0] s2_hi, s2_val;
    s2_hi  = 21'h12491E;  // strobe[0] high on 1-4, 8, 11, 14, 17, 20
    s2_val = 21'h124902;  // key_valid on 1, 8, 11, 14, 17, 20

    tick(); tick();
    check("reset_strobe", 32'(strobe), 32'h0);
    check("reset_key_code", 32'(key_code), 32'h0);
    RST_N = 1'b1;
    tick(); tick();

    // Single press, no repeat
    detect = 4'b0001;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) begin
        check("s1_strobe_c1", 32'(strobe), 32'h1);
        check("s1_valid_c1", 32'(key_valid), 32'h1);
        check("s1_code_c1", 32'(key_code), 32'h0);
        check("s1_multi_c1", 32'(key_multi), 32'h0);
      end
      if (n == 2) check("s1_valid_c2", 32'(key_valid), 32'h0);
      if (n == 4) check("s1_strobe_c4", 32'(strobe), 32'h1);
      if (n >= 5) check("s1_strobe_locked", 32'(strobe), 32'h0);
    end
    detect = '0; tick(); tick();

    // Auto-repeat
    repeat_en = 1'b1;
    detect = 4'b0001;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check("s2_strobe", 32'(strobe[0]), 32'(s2_hi[n]));
      check("s2_valid", 32'(key_valid), 32'(s2_val[n]));
    end
    detect = '0; repeat_en = 1'b0; tick(); tick();

    // Early release and re-press
    detect = 4'b0001;
    tick(); tick();
    check("s3_strobe_c2", 32'(strobe), 32'h1);
    detect = '0;
    tick();
    check("s3_strobe_release", 32'(strobe), 32'h0);
    tick();
    detect = 4'b0001;
    for (int n = 1; n <= 5; n++) begin
      tick();
      check("s3_repress", 32'(strobe), (n <= 4) ? 32'h1 : 32'h0);
    end
    detect = '0; tick(); tick();

    // Simultaneous press on channels 1 and 3
    detect = 4'b1010;
    tick();
    check("s4_strobe", 32'(strobe), 32'hA);
    check("s4_valid", 32'(key_valid), 32'h1);
    check("s4_code", 32'(key_code), 32'h1);
    check("s4_multi", 32'(key_multi), 32'h1);
    tick(); tick(); tick();
    check("s4_strobe_c4", 32'(strobe), 32'hA);
    tick();
    check("s4_strobe_c5", 32'(strobe), 32'h0);
    check("s4_code_hold", 32'(key_code), 32'h1);
    detect = '0; tick(); tick();

    // Reset mid-hold, key held through reset
    detect = 4'b0001;
    tick(); tick();
    check("s5_strobe_c2", 32'(strobe), 32'h1);
    RST_N = 1'b0;
    #1;
    check("s5_async_strobe", 32'(strobe), 32'h0);
    check("s5_async_code", 32'(key_code), 32'h0);
    tick();
    RST_N = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      check("s5_held_no_strobe", 32'(strobe), 32'h0);
    end
    detect = '0; tick(); tick();
    detect = 4'b0001;
    for (int n = 1; n <= 5; n++) begin
      tick();
      check("s5_repress", 32'(strobe), (n <= 4) ? 32'h1 : 32'h0);
    end
    detect = '0; tick(); tick();

    // Repeat mode dropped during the gap
    repeat_en = 1'b1;
    detect = 4'b0001;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 8) check("s6_pulse_c8", 32'(strobe), 32'h1);
    end
    check("s6_gap_c9", 32'(strobe), 32'h0);
    repeat_en = 1'b0;
    for (int n = 10; n <= 17; n++) begin
      tick();
      check("s6_dropped", 32'(strobe), 32'h0);
    end
    detect = '0; tick(); tick();
    detect = 4'b0001;
    tick();
    check("s6_repress", 32'(strobe), 32'h1);
    check("s6_repress_valid", 32'(key_valid), 32'h1);
    tick(); tick(); tick();
    detect = '0; tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
